// File: rtl/des_key_sched.sv
// DES key-schedule controller: holds C/D, drives the external shift stage and
// presents one PC2 subkey per round in encrypt (K1..K16) or decrypt (K16..K1) order.
//
// state | meaning
// IDLE  | no key loaded, outputs quiet, waiting for i_start
// ROUND | subkey for o_round valid, waiting for i_next
module des_key_sched #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [63:0] i_key,
  input  logic        i_mode,
  input  logic        i_next,
  output logic [55:0] o_cd,
  output logic [2:0]  o_func,
  input  logic [55:0] i_cd_shifted,
  output logic [47:0] o_subkey,
  output logic        o_valid,
  output logic [3:0]  o_round,
  output logic        o_busy
);

  typedef enum logic {IDLE, ROUND} state_t;

  localparam logic [2:0] F_L1   = 3'd0;
  localparam logic [2:0] F_L2   = 3'd1;
  localparam logic [2:0] F_R1   = 3'd2;
  localparam logic [2:0] F_R2   = 3'd3;
  localparam logic [2:0] F_KEEP = 3'd4;
  localparam logic [3:0] LAST   = 4'(NUM_ROUNDS - 1);

  // FIPS 46-3 tables, 1-based with bit 1 = MSB
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic [55:0] pc1_key;
  logic [47:0] pc2_cd;
  logic        one_step;

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_key[55-g] = i_key[64-PC1[g]];
  end

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign pc2_cd[47-g] = i_cd_shifted[56-PC2[g]];
  end

  // parity bits (DES bits 8, 16, ..., 64) are dropped by PC1
  logic unused_parity;
  assign unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                           i_key[24], i_key[16], i_key[8], i_key[0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ROUND;
          cd_d    = pc1_key;
          round_d = '0;
          mode_d  = i_mode;
        end
      end
      ROUND: begin
        if (i_next) begin
          if (round_q == LAST) begin
            state_d = IDLE;
            cd_d    = '0;
            round_d = '0;
          end else begin
            cd_d    = i_cd_shifted;
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rounds 1, 2, 9, 16 shift by one; decrypt starts from C16D16 = C0D0 so round 1 keeps
  always_comb begin
    o_func   = F_KEEP;
    one_step = (round_q == 4'd1) || (round_q == 4'd8) || (round_q == LAST);
    if (state_q == ROUND) begin
      if (!mode_q)
        o_func = (one_step || round_q == 4'd0) ? F_L1 : F_L2;
      else if (round_q != 4'd0)
        o_func = one_step ? F_R1 : F_R2;
    end
  end

  assign o_valid  = (state_q == ROUND);
  assign o_busy   = (state_q != IDLE);
  assign o_cd     = cd_q;
  assign o_round  = round_q;
  assign o_subkey = o_valid ? pc2_cd : '0;

endmodule
